// File: rtl/filter_pkg.sv
// Shared constants and types for the horizontal low-pass stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package filter_pkg;

    // Default output pixel width and the derived input / sum widths.
    localparam int PB    = 8;
    localparam int IN_W  = PB + 2;
    localparam int SUM_W = PB + 4;

    // Total 2-D kernel weight, coded: 3x3=9, 3x4=12, 4x4=16.
    typedef enum logic [1:0] {
        W9  = 2'd0,
        W12 = 2'd1,
        W16 = 2'd2
    } wcode_e;

    // Fixed-point reciprocals (scaled by 2^RSHIFT), exact for sums up to 4080.
    localparam int R9      = 7282;
    localparam int R12     = 5462;
    localparam int RSHIFT  = 16;
    localparam int RECIP_W = 13;

    // A column edge drops the horizontal weight to 3, a row edge the vertical one.
    function automatic wcode_e wcode_sel(input logic edge_col, input logic edge_row);
        if (edge_col && edge_row) begin
            return W9;
        end else if (edge_col || edge_row) begin
            return W12;
        end
        return W16;
    endfunction

endpackage

// File: rtl/xfilter_norm.sv
// Divides the 1-2-1 sum by the 2-D kernel weight (9, 12 or 16), flags ride along.
// Latency: 2 cycles (multiply stage, shift/select stage).
// Backpressure: none; outputs hold their last value while o_valid is low.
//
// Ports: i_vld/i_sum/i_wcode/i_col1/i_colN/i_rowM in, o_valid/o_pixel/o_col1/o_colN/o_rowM out.
module xfilter_norm
    import filter_pkg::*;
#(
    parameter int PB = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_vld,
    input  logic [PB+3:0] i_sum,
    input  logic [1:0]    i_wcode,
    input  logic          i_col1,
    input  logic          i_colN,
    input  logic          i_rowM,
    output logic          o_valid,
    output logic [PB-1:0] o_pixel,
    output logic          o_col1,
    output logic          o_colN,
    output logic          o_rowM
);

    localparam int PW = PB + 4 + RECIP_W;

    logic               s1_vld_q,   s1_vld_d;
    logic [PW-1:0]      s1_prod_q,  s1_prod_d;
    logic [PB+3:0]      s1_sum_q,   s1_sum_d;
    logic               s1_w16_q,   s1_w16_d;
    logic [2:0]         s1_flags_q, s1_flags_d;
    logic               out_vld_q,  out_vld_d;
    logic [PB-1:0]      out_pix_q,  out_pix_d;
    logic [2:0]         out_flags_q, out_flags_d;
    logic [RECIP_W-1:0] recip;

    always_comb begin
        recip       = (i_wcode == W9) ? RECIP_W'(R9) : RECIP_W'(R12);
        s1_vld_d    = i_vld;
        s1_prod_d   = PW'(i_sum) * PW'(recip);
        s1_sum_d    = i_sum;
        s1_w16_d    = (i_wcode == W16);
        s1_flags_d  = {i_col1, i_colN, i_rowM};

        out_vld_d   = s1_vld_q;
        out_pix_d   = out_pix_q;
        out_flags_d = out_flags_q;
        if (s1_vld_q) begin
            // Weight 16 is a plain shift; 9 and 12 take the reciprocal product.
            out_pix_d   = s1_w16_q ? PB'(s1_sum_q >> 4) : PB'(s1_prod_q >> RSHIFT);
            out_flags_d = s1_flags_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q    <= 1'b0;
            s1_prod_q   <= '0;
            s1_sum_q    <= '0;
            s1_w16_q    <= 1'b0;
            s1_flags_q  <= '0;
            out_vld_q   <= 1'b0;
            out_pix_q   <= '0;
            out_flags_q <= '0;
        end else begin
            s1_vld_q    <= s1_vld_d;
            s1_prod_q   <= s1_prod_d;
            s1_sum_q    <= s1_sum_d;
            s1_w16_q    <= s1_w16_d;
            s1_flags_q  <= s1_flags_d;
            out_vld_q   <= out_vld_d;
            out_pix_q   <= out_pix_d;
            out_flags_q <= out_flags_d;
        end
    end

    assign o_valid = out_vld_q;
    assign o_pixel = out_pix_q;
    assign o_col1  = out_flags_q[2];
    assign o_colN  = out_flags_q[1];
    assign o_rowM  = out_flags_q[0];

endmodule

// File: rtl/xfilter.sv
// Horizontal 1-2-1 filter on vertical column sums, normalised by the full 2-D weight.
// Latency: output 3 cycles after the emit event (4 cycles after colN for the last pixel).
// Backpressure: none; input gaps allowed anywhere, outputs hold while o_valid is low.
//
// Ports: clk/rst; i_valid_filt, i_filt_pixel (PB+2), i_col1/i_colN/i_rowM in;
//        o_valid, o_pixel (PB), o_col1/o_colN/o_rowM out.
module xfilter
    import filter_pkg::*;
#(
    parameter int PB = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid_filt,
    input  logic [PB+1:0] i_filt_pixel,
    input  logic          i_col1,
    input  logic          i_colN,
    input  logic          i_rowM,
    output logic          o_valid,
    output logic [PB-1:0] o_pixel,
    output logic          o_col1,
    output logic          o_colN,
    output logic          o_rowM
);

    localparam int IW = PB + 2;
    localparam int SW = PB + 4;

    // Window: prev/cur taps plus cur's position flags.
    logic [IW-1:0] prev_q,     prev_d;
    logic [IW-1:0] cur_q,      cur_d;
    logic          cur_col1_q, cur_col1_d;
    logic          cur_rowM_q, cur_rowM_d;
    logic          cur_top_q,  cur_top_d;
    logic          in_row_q,   in_row_d;
    logic          top_row_q,  top_row_d;
    logic          flush_q,    flush_d;

    // Sum stage feeding the divider.
    logic          s0_vld_q,   s0_vld_d;
    logic [SW-1:0] s0_sum_q,   s0_sum_d;
    wcode_e        s0_wcode_q, s0_wcode_d;
    logic          s0_col1_q,  s0_col1_d;
    logic          s0_colN_q,  s0_colN_d;
    logic          s0_rowM_q,  s0_rowM_d;

    logic          accept, acc_col1, acc_mid, emit;
    logic [IW-1:0] tap_l, tap_r;
    logic [SW-1:0] sum_w;

    always_comb begin
        prev_d     = prev_q;
        cur_d      = cur_q;
        cur_col1_d = cur_col1_q;
        cur_rowM_d = cur_rowM_q;
        cur_top_d  = cur_top_q;
        in_row_d   = in_row_q;
        top_row_d  = top_row_q;
        flush_d    = 1'b0;

        // Single-column rows (col1 and colN together) are not supported: ignore them.
        accept   = i_valid_filt && !(i_col1 && i_colN);
        acc_col1 = accept && i_col1;
        acc_mid  = accept && !i_col1 && in_row_q;

        // A flush only follows colN, after in_row has cleared, so it never
        // coincides with acc_mid; the right tap is absent only on flush.
        emit  = acc_mid || flush_q;
        tap_l = cur_col1_q ? '0 : prev_q;
        tap_r = flush_q ? '0 : i_filt_pixel;
        sum_w = SW'(tap_l) + (SW'(cur_q) << 1) + SW'(tap_r);

        s0_vld_d   = emit;
        s0_sum_d   = s0_sum_q;
        s0_wcode_d = s0_wcode_q;
        s0_col1_d  = s0_col1_q;
        s0_colN_d  = s0_colN_q;
        s0_rowM_d  = s0_rowM_q;
        if (emit) begin
            s0_sum_d   = sum_w;
            s0_wcode_d = wcode_sel(cur_col1_q || flush_q, cur_top_q || cur_rowM_q);
            s0_col1_d  = cur_col1_q;
            s0_colN_d  = flush_q;
            s0_rowM_d  = cur_rowM_q;
        end

        if (acc_col1) begin
            // Also restarts a row in progress; the pending cur is dropped.
            cur_d      = i_filt_pixel;
            cur_col1_d = 1'b1;
            cur_rowM_d = i_rowM;
            cur_top_d  = top_row_q;
            in_row_d   = 1'b1;
        end else if (acc_mid) begin
            prev_d     = cur_q;
            cur_d      = i_filt_pixel;
            cur_col1_d = 1'b0;
            cur_rowM_d = i_rowM;
            if (i_colN) begin
                in_row_d  = 1'b0;
                flush_d   = 1'b1;
                // The row after the frame's last row starts a new frame.
                top_row_d = i_rowM;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q     <= '0;
            cur_q      <= '0;
            cur_col1_q <= 1'b0;
            cur_rowM_q <= 1'b0;
            cur_top_q  <= 1'b0;
            in_row_q   <= 1'b0;
            top_row_q  <= 1'b1;
            flush_q    <= 1'b0;
            s0_vld_q   <= 1'b0;
            s0_sum_q   <= '0;
            s0_wcode_q <= W16;
            s0_col1_q  <= 1'b0;
            s0_colN_q  <= 1'b0;
            s0_rowM_q  <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            cur_q      <= cur_d;
            cur_col1_q <= cur_col1_d;
            cur_rowM_q <= cur_rowM_d;
            cur_top_q  <= cur_top_d;
            in_row_q   <= in_row_d;
            top_row_q  <= top_row_d;
            flush_q    <= flush_d;
            s0_vld_q   <= s0_vld_d;
            s0_sum_q   <= s0_sum_d;
            s0_wcode_q <= s0_wcode_d;
            s0_col1_q  <= s0_col1_d;
            s0_colN_q  <= s0_colN_d;
            s0_rowM_q  <= s0_rowM_d;
        end
    end

    xfilter_norm #(.PB(PB)) u_norm (
        .clk     (clk),
        .rst     (rst),
        .i_vld   (s0_vld_q),
        .i_sum   (s0_sum_q),
        .i_wcode (s0_wcode_q),
        .i_col1  (s0_col1_q),
        .i_colN  (s0_colN_q),
        .i_rowM  (s0_rowM_q),
        .o_valid (o_valid),
        .o_pixel (o_pixel),
        .o_col1  (o_col1),
        .o_colN  (o_colN),
        .o_rowM  (o_rowM)
    );

endmodule

// File: tb/tb_xfilter.sv
module tb_xfilter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_valid_filt = 1'b0;
    logic [9:0] i_filt_pixel = '0;
    logic       i_col1 = 1'b0;
    logic       i_colN = 1'b0;
    logic       i_rowM = 1'b0;
    logic       o_valid;
    logic [7:0] o_pixel;
    logic       o_col1;
    logic       o_colN;
    logic       o_rowM;

    xfilter #(.PB(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_valid_filt (i_valid_filt),
        .i_filt_pixel (i_filt_pixel),
        .i_col1       (i_col1),
        .i_colN       (i_colN),
        .i_rowM       (i_rowM),
        .o_valid      (o_valid),
        .o_pixel      (o_pixel),
        .o_col1       (o_col1),
        .o_colN       (o_colN),
        .o_rowM       (o_rowM)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  pix;
        logic        c1;
        logic        cn;
        logic        rm;
        logic [31:0] t;
    } ev_t;

    ev_t got_q[$];
    ev_t exp_q[$];
    int  n_total = 0;
    int  n_pass  = 0;
    bit  tb_top  = 1'b1;   // next row is the first row of a frame
    int  row_vals[16];

    // Every valid output, stamped with the time of the falling edge it was seen on.
    always @(negedge clk) begin
        if (o_valid) got_q.push_back(ev_t'{o_pixel, o_col1, o_colN, o_rowM, 32'($time)});
    end

    function automatic string fmt(input ev_t e);
        return $sformatf("pix=%0d c1=%0b cn=%0b rm=%0b t=%0d", e.pix, e.c1, e.cn, e.rm, e.t);
    endfunction

    // One input cycle: drive on the falling edge, return the sampling edge time.
    task automatic drive(input bit v, input int data, input bit c1, input bit cn,
                         input bit rm, output int t);
        @(negedge clk);
        i_valid_filt = v;
        i_filt_pixel = 10'(data);
        i_col1       = c1;
        i_colN       = cn;
        i_rowM       = rm;
        @(posedge clk);
        t = int'($time);
    endtask

    // Idle cycles carry random data and flags that must be ignored.
    task automatic idle(input int n);
        int t;
        for (int i = 0; i < n; i++)
            drive(1'b0, int'($urandom_range(0, 1023)), 1'($urandom), 1'($urandom), 1'($urandom), t);
    endtask

    function automatic int max_val(input bit bot);
        return (tb_top || bot) ? 765 : 1020;
    endfunction

    // Drives row_vals[0..n-1] as one row and queues the reference outputs:
    // out[j] = floor((v[j-1] + 2v[j] + v[j+1]) / (wh*wv)), missing taps 0,
    // wh=3 at row ends, wv=3 in a frame's first or last row. Column j appears
    // 3 cycles after column j+1 is accepted; the last column 4 cycles after it
    // is accepted. An incomplete row (no colN) never emits its last pixel.
    task automatic send_row(input int n, input bit bot, input bit complete, input int max_gap);
        int  ts[16];
        int  l, r, wh, wv, m;
        ev_t e;
        for (int i = 0; i < n; i++) begin
            idle(int'($urandom_range(0, max_gap)));
            drive(1'b1, row_vals[i], i == 0, complete && (i == n - 1), bot, ts[i]);
        end
        wv = (tb_top || bot) ? 3 : 4;
        m  = complete ? n : n - 1;
        for (int j = 0; j < m; j++) begin
            l     = (j > 0) ? row_vals[j-1] : 0;
            r     = (j < n - 1) ? row_vals[j+1] : 0;
            wh    = (j == 0 || j == n - 1) ? 3 : 4;
            e.pix = 8'((l + 2 * row_vals[j] + r) / (wh * wv));
            e.c1  = (j == 0);
            e.cn  = (j == n - 1);
            e.rm  = bot;
            e.t   = 32'((j < n - 1) ? ts[j+1] + 25 : ts[j] + 35);
            exp_q.push_back(e);
        end
        if (complete) tb_top = bot;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_total++; if (o_valid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", o_valid); else n_pass++;
        n_total++; if (o_pixel !== 8'd0) $display("FAIL reset_pixel: got %0d expected 0", o_pixel); else n_pass++;
        n_total++; if ({o_col1, o_colN, o_rowM} !== 3'b000)
            $display("FAIL reset_flags: got %b expected 000", {o_col1, o_colN, o_rowM}); else n_pass++;
        got_q.delete();
        idle(4);
        n_total++; if (got_q.size() !== 0) $display("FAIL reset_idle: got %0d outputs expected 0", got_q.size()); else n_pass++;
        tb_top = 1'b1;
    endtask

    task automatic test_flat_top;
        got_q.delete(); exp_q.delete();
        for (int i = 0; i < 4; i++) row_vals[i] = 300;
        send_row(4, 1'b0, 1'b1, 0);
        idle(8);
        n_total++; if (got_q.size() !== exp_q.size())
            $display("FAIL flat_count: got %0d expected %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_total++; if (got_q[i] !== exp_q[i])
                $display("FAIL flat_ev%0d: got %s expected %s", i, fmt(got_q[i]), fmt(exp_q[i])); else n_pass++;
        end
        // Outputs hold the last pixel (100, colN) while idle.
        @(negedge clk);
        n_total++; if ({o_valid, o_pixel, o_colN} !== {1'b0, 8'd100, 1'b1})
            $display("FAIL flat_hold: got v=%0b pix=%0d cn=%0b expected v=0 pix=100 cn=1", o_valid, o_pixel, o_colN);
        else n_pass++;
    endtask

    task automatic test_middle;
        got_q.delete(); exp_q.delete();
        row_vals[0] = 0; row_vals[1] = 1020; row_vals[2] = 0; row_vals[3] = 0;
        send_row(4, 1'b0, 1'b1, 1);
        idle(8);
        n_total++; if (got_q.size() !== 4) $display("FAIL mid_count: got %0d expected 4", got_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_total++; if (got_q[i] !== exp_q[i])
                $display("FAIL mid_ev%0d: got %s expected %s", i, fmt(got_q[i]), fmt(exp_q[i])); else n_pass++;
        end
    endtask

    task automatic test_back_to_back;
        got_q.delete(); exp_q.delete();
        for (int i = 0; i < 4; i++) row_vals[i] = 400;
        send_row(4, 1'b0, 1'b1, 0);
        send_row(4, 1'b0, 1'b1, 0);
        idle(8);
        n_total++; if (got_q.size() !== 8) $display("FAIL b2b_count: got %0d expected 8", got_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_total++; if (got_q[i] !== exp_q[i])
                $display("FAIL b2b_ev%0d: got %s expected %s", i, fmt(got_q[i]), fmt(exp_q[i])); else n_pass++;
        end
    endtask

    task automatic test_frame_wrap;
        got_q.delete(); exp_q.delete();
        for (int i = 0; i < 4; i++) row_vals[i] = 300;
        send_row(4, 1'b1, 1'b1, 1);   // last row of the current frame
        send_row(4, 1'b0, 1'b1, 0);   // new frame, top row
        send_row(4, 1'b1, 1'b1, 0);   // two-row frame: bottom row
        send_row(4, 1'b0, 1'b1, 1);   // next frame, top row again
        idle(8);
        n_total++; if (got_q.size() !== exp_q.size())
            $display("FAIL wrap_count: got %0d expected %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_total++; if (got_q[i] !== exp_q[i])
                $display("FAIL wrap_ev%0d: got %s expected %s", i, fmt(got_q[i]), fmt(exp_q[i])); else n_pass++;
        end
    endtask

    task automatic test_random;
        int n;
        bit bot;
        got_q.delete(); exp_q.delete();
        for (int r = 0; r < 10; r++) begin
            n   = int'($urandom_range(2, 9));
            bot = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < n; i++) row_vals[i] = int'($urandom_range(0, max_val(bot)));
            send_row(n, bot, 1'b1, int'($urandom_range(0, 2)));
        end
        idle(8);
        n_total++; if (got_q.size() !== exp_q.size())
            $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_total++; if (got_q[i] !== exp_q[i])
                $display("FAIL rand_ev%0d: got %s expected %s", i, fmt(got_q[i]), fmt(exp_q[i])); else n_pass++;
        end
    endtask

    task automatic test_deviation;
        int t;
        got_q.delete(); exp_q.delete();
        drive(1'b1, 500, 1'b0, 1'b0, 1'b0, t);   // stray: no row open
        drive(1'b1, 600, 1'b0, 1'b1, 1'b0, t);   // stray colN
        drive(1'b1, 700, 1'b1, 1'b1, 1'b0, t);   // single-column row
        idle(8);
        n_total++; if (got_q.size() !== 0) $display("FAIL dev_stray: got %0d outputs expected 0", got_q.size()); else n_pass++;
        for (int i = 0; i < 3; i++) row_vals[i] = int'($urandom_range(0, max_val(1'b0)));
        send_row(3, 1'b0, 1'b0, 1);              // abandoned by the next col1
        for (int i = 0; i < 5; i++) row_vals[i] = int'($urandom_range(0, max_val(1'b0)));
        send_row(5, 1'b0, 1'b1, 1);
        idle(8);
        n_total++; if (got_q.size() !== 7) $display("FAIL dev_count: got %0d expected 7", got_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_total++; if (got_q[i] !== exp_q[i])
                $display("FAIL dev_ev%0d: got %s expected %s", i, fmt(got_q[i]), fmt(exp_q[i])); else n_pass++;
        end
    endtask

    task automatic test_reset_mid;
        got_q.delete(); exp_q.delete();
        for (int i = 0; i < 3; i++) row_vals[i] = int'($urandom_range(1, max_val(1'b0)));
        send_row(3, 1'b0, 1'b0, 0);
        exp_q.delete();                           // killed by reset, never seen
        @(negedge clk);
        i_valid_filt = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tb_top = 1'b1;
        n_total++; if ({o_valid, o_pixel} !== 9'd0)
            $display("FAIL rstmid_out: got v=%0b pix=%0d expected v=0 pix=0", o_valid, o_pixel); else n_pass++;
        idle(6);
        n_total++; if (got_q.size() !== 0) $display("FAIL rstmid_kill: got %0d outputs expected 0", got_q.size()); else n_pass++;
        for (int i = 0; i < 4; i++) row_vals[i] = 300;
        send_row(4, 1'b0, 1'b1, 0);
        idle(8);
        n_total++; if (got_q.size() !== 4) $display("FAIL rstmid_count: got %0d expected 4", got_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_total++; if (got_q[i] !== exp_q[i])
                $display("FAIL rstmid_ev%0d: got %s expected %s", i, fmt(got_q[i]), fmt(exp_q[i])); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_flat_top();
        test_middle();
        test_back_to_back();
        test_frame_wrap();
        test_random();
        test_deviation();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
